fft_frame_loader: RTL

Streaming front end for the parallel FFT core. Accepts one ADC sample per cycle over a valid/ready interface, assembles frames of N = 2^LOG2_N samples into a ping-pong pair of register banks, and presents each complete frame as a flat parallel bus with a one-cycle `start` pulse. It holds that bus stable until the core's `finish`, while the other bank keeps filling. It generalises the fixed 32-lane parallel input to a parametrised point count, adds optional bit-reversed load order, frame resync and an overrun counter.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_frame_loader_if.sv | 22 ++
 rtl/fft_frame_bank.sv | 23 ++
 rtl/fft_frame_loader.sv | 109 ++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizing, presenter state encoding and the
// lane bit-reversal helper used by the frame loader.
package fft_pkg;

  localparam int unsigned ADC_DATA_WIDTH_DEF = 8;
  localparam int unsigned LOG2_N_DEF         = 5;

  typedef enum logic [1:0] {
    PS_IDLE  = 2'd0,
    PS_START = 2'd1,
    PS_WAIT  = 2'd2
  } pres_state_t;

  // Reverses the low log2_n bits of k; upper bits of the result are zero.
  function automatic logic [15:0] bitrev(input logic [15:0] k, input int unsigned log2_n);
    logic [15:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < log2_n) r[i[3:0]] = k[4'(log2_n - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample stream and frame presentation signals between the ADC side, the
// frame loader and the parallel FFT core.
interface fft_frame_loader_if
  import fft_pkg::*;
#(
  parameter int unsigned W      = ADC_DATA_WIDTH_DEF,
  parameter int unsigned LOG2_N = LOG2_N_DEF
);
  logic                      s_valid;
  logic [W-1:0]              s_data;
  logic                      s_first;
  logic                      s_ready;
  logic [(W<<LOG2_N)-1:0]    frame_data;
  logic                      start;
  logic                      finish;
  logic                      busy;

  modport master (output s_valid, s_data, s_first, finish,
                  input  s_ready, frame_data, start, busy);
  modport slave  (input  s_valid, s_data, s_first, finish,
                  output s_ready, frame_data, start, busy);
endinterface

// File: rtl/fft_frame_bank.sv
// One N x W sample bank: single lane write port, async clear, flat read-out.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int unsigned W      = ADC_DATA_WIDTH_DEF,
  parameter int unsigned LOG2_N = LOG2_N_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [LOG2_N-1:0]      idx,
  input  logic [W-1:0]           din,
  output logic [(W<<LOG2_N)-1:0] dout
);
  logic [(W<<LOG2_N)-1:0] mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   mem <= '0;
    else if (we) mem[idx*W +: W] <= din;
  end

  assign dout = mem;
endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong frame assembler: streams samples into two banks and presents each
// completed bank to the FFT core with a start pulse, holding it until finish.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int unsigned ADC_DATA_WIDTH = ADC_DATA_WIDTH_DEF,
  parameter int unsigned LOG2_N         = LOG2_N_DEF,
  parameter bit          BIT_REVERSE    = 1'b0,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      PU_enable,
  fft_frame_loader_if.slave         bus,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);
  localparam int unsigned W = ADC_DATA_WIDTH;
  localparam logic [LOG2_N-1:0] LAST = LOG2_N'((1 << LOG2_N) - 1);
  localparam logic [LOG2_N-1:0] ONE  = LOG2_N'(1);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = DROP_CNT_WIDTH'(1);

  logic [1:0]              full;
  logic [1:0]              avail;
  logic                    wbank, pbank, pbank_nxt;
  logic [LOG2_N-1:0]       wptr, widx, lane;
  logic                    accept, resync, wrap, release_f;
  logic [(W<<LOG2_N)-1:0]  bank_q [2];
  pres_state_t             state, state_nxt;

  assign bus.s_ready = !reset && PU_enable && !full[wbank];
  assign accept      = bus.s_valid && bus.s_ready;
  assign resync      = bus.s_first && (wptr != '0);
  assign widx        = resync ? '0 : wptr;
  assign lane        = BIT_REVERSE ? LOG2_N'(bitrev(16'(widx), LOG2_N)) : widx;
  assign wrap        = accept && !resync && (wptr == LAST);
  assign release_f   = (state == PS_WAIT) && bus.finish;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(.W(W), .LOG2_N(LOG2_N)) u_bank (
      .clk  (clk),
      .reset(reset),
      .we   (accept && (wbank == 1'(b))),
      .idx  (lane),
      .din  (bus.s_data),
      .dout (bank_q[b])
    );
  end

  assign bus.frame_data = pbank ? bank_q[1] : bank_q[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbank <= 1'b0;
      wptr  <= '0;
      full  <= '0;
    end else begin
      if (accept) begin
        if (resync)              wptr <= ONE;
        else if (wptr == LAST) begin
          wptr  <= '0;
          wbank <= ~wbank;
        end else                 wptr <= wptr + ONE;
      end
      if (wrap)      full[wbank] <= 1'b1;
      if (release_f) full[pbank] <= 1'b0;
    end
  end

  // A bank completing on this edge counts as available so start follows the
  // last sample by one cycle; with two candidates the older one goes first.
  always_comb begin
    avail = full | (wrap ? (wbank ? 2'b10 : 2'b01) : 2'b00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PS_IDLE;
      pbank <= 1'b0;
    end else begin
      state <= state_nxt;
      pbank <= pbank_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pbank_nxt = pbank;
    case (state)
      PS_IDLE: begin
        if (PU_enable && (avail != 2'b00)) begin
          state_nxt = PS_START;
          pbank_nxt = (avail == 2'b11) ? ~wbank : avail[1];
        end
      end
      PS_START: state_nxt = PS_WAIT;
      PS_WAIT:  if (bus.finish) state_nxt = PS_IDLE;
      default:  state_nxt = PS_IDLE;
    endcase
  end

  assign bus.start = (state == PS_START);
  assign bus.busy  = (state != PS_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt <= '0;
    else if (PU_enable && bus.s_valid && !bus.s_ready && (drop_cnt != '1))
      drop_cnt <= drop_cnt + DROP_ONE;
  end
endmodule
